// File: rtl/slurm16_cpu_writeback_tracker_pkg.sv
// +----------------------------------------------------------------------------+
// | slurm16_cpu_writeback_tracker_pkg                                          |
// | Shared instruction classes, decode helpers and writeback entry type.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package slurm16_cpu_writeback_tracker_pkg;

    localparam int INS_BITS     = 16;
    localparam int REG_SEL_BITS = 4;
    localparam int REG_COUNT    = 16;

    localparam logic [REG_SEL_BITS-1:0] LINK_REGISTER = 4'd15;

    // Instruction classes; '?' bits are don't-care when matched with casez.
    localparam logic [INS_BITS-1:0] INSTRUCTION_CASEX_NOP              = 16'b0000_0000_0000_0000;
    localparam logic [INS_BITS-1:0] INSTRUCTION_CASEX_RET_IRET         = 16'b0000_0001_????_????;
    localparam logic [INS_BITS-1:0] INSTRUCTION_CASEX_ALUOP_SINGLE_REG = 16'b0000_0100_????_????;
    localparam logic [INS_BITS-1:0] INSTRUCTION_CASEX_ALUOP_REG_REG    = 16'b0010_????_????_????;
    localparam logic [INS_BITS-1:0] INSTRUCTION_CASEX_ALUOP_REG_IMM    = 16'b0011_????_????_????;
    localparam logic [INS_BITS-1:0] INSTRUCTION_CASEX_BRANCH           = 16'b0100_????_????_????;
    localparam logic [INS_BITS-1:0] INSTRUCTION_CASEX_PEEK_POKE        = 16'b0101_????_????_????;
    localparam logic [INS_BITS-1:0] INSTRUCTION_CASEX_LOAD_STORE       = 16'b1???_????_????_????;

    typedef struct packed {
        logic                    valid;
        logic [REG_SEL_BITS-1:0] dest;
        logic                    is_mem;
    } wb_entry_t;

    localparam int        WB_VALID_BITS = 1;
    localparam int        WB_DEST_BITS  = REG_SEL_BITS;
    localparam int        WB_MEM_BITS   = 1;
    localparam int        WB_ENTRY_BITS = WB_VALID_BITS + WB_DEST_BITS + WB_MEM_BITS;
    localparam wb_entry_t WB_BUBBLE     = '0;

    function automatic logic [REG_SEL_BITS-1:0] reg_dest_from_ins(input logic [INS_BITS-1:0] ins);
        return ins[7:4];
    endfunction

    function automatic logic [REG_SEL_BITS-1:0] reg_src_from_ins(input logic [INS_BITS-1:0] ins);
        return ins[3:0];
    endfunction

    // Bit 12 separates loads from stores inside the load/store class.
    function automatic logic is_load_from_ins(input logic [INS_BITS-1:0] ins);
        return ins[12];
    endfunction

    function automatic logic is_peek_from_ins(input logic [INS_BITS-1:0] ins);
        return ins[8];
    endfunction

    function automatic logic is_link_from_ins(input logic [INS_BITS-1:0] ins);
        return ins[8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/slurm16_cpu_writeback_tracker_if.sv
// +----------------------------------------------------------------------------+
// | slurm16_cpu_writeback_tracker_if                                           |
// | Pipeline-side bus of the writeback tracker. Optional: SLURM16_WB_STALL_STATS_EN |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface slurm16_cpu_writeback_tracker_if;
    import slurm16_cpu_writeback_tracker_pkg::*;

    logic [INS_BITS-1:0]     instruction;
    logic                    ins_valid;
    logic                    stall;
    logic                    flush;
    logic [REG_SEL_BITS-1:0] hazard_regA_sel;
    logic [REG_SEL_BITS-1:0] hazard_regB_sel;
    logic [REG_SEL_BITS-1:0] wr_sel;
    logic                    wr_en;
    logic                    hazard_stall;
    logic [REG_COUNT-1:0]    pending_mask;
`ifdef SLURM16_WB_STALL_STATS_EN
    logic [15:0]             stall_count;
`endif

    modport master (
        output instruction, ins_valid, stall, flush, hazard_regA_sel, hazard_regB_sel,
        input  wr_sel, wr_en, hazard_stall, pending_mask
`ifdef SLURM16_WB_STALL_STATS_EN
        , input stall_count
`endif
    );

    modport slave (
        input  instruction, ins_valid, stall, flush, hazard_regA_sel, hazard_regB_sel,
        output wr_sel, wr_en, hazard_stall, pending_mask
`ifdef SLURM16_WB_STALL_STATS_EN
        , output stall_count
`endif
    );

endinterface

`default_nettype wire

// File: rtl/slurm16_cpu_wb_dest_decode.sv
// +----------------------------------------------------------------------------+
// | slurm16_cpu_wb_dest_decode                                                 |
// | Instruction -> destination-register write intent {valid, dest, is_mem}.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module slurm16_cpu_wb_dest_decode
    import slurm16_cpu_writeback_tracker_pkg::*;
(
    input  logic [INS_BITS-1:0] instruction,
    output wb_entry_t           entry
);

    always_comb begin
        entry = WB_BUBBLE;
        casez (instruction)
            INSTRUCTION_CASEX_NOP, INSTRUCTION_CASEX_RET_IRET: begin
                entry = WB_BUBBLE;
            end
            INSTRUCTION_CASEX_ALUOP_SINGLE_REG: begin
                entry = '{valid: 1'b1, dest: reg_src_from_ins(instruction), is_mem: 1'b0};
            end
            INSTRUCTION_CASEX_ALUOP_REG_REG, INSTRUCTION_CASEX_ALUOP_REG_IMM: begin
                entry = '{valid: 1'b1, dest: reg_dest_from_ins(instruction), is_mem: 1'b0};
            end
            INSTRUCTION_CASEX_LOAD_STORE: begin
                if (is_load_from_ins(instruction))
                    entry = '{valid: 1'b1, dest: reg_dest_from_ins(instruction), is_mem: 1'b1};
            end
            INSTRUCTION_CASEX_PEEK_POKE: begin
                if (is_peek_from_ins(instruction))
                    entry = '{valid: 1'b1, dest: reg_dest_from_ins(instruction), is_mem: 1'b1};
            end
            INSTRUCTION_CASEX_BRANCH: begin
                if (is_link_from_ins(instruction))
                    entry = '{valid: 1'b1, dest: LINK_REGISTER, is_mem: 1'b0};
            end
            default: begin
                entry = WB_BUBBLE;
            end
        endcase
        // r0 is hardwired zero, so a write to it is no write at all.
        if (entry.dest == '0)
            entry = WB_BUBBLE;
    end

endmodule

`default_nettype wire

// File: rtl/slurm16_cpu_writeback_tracker.sv
// +----------------------------------------------------------------------------+
// | slurm16_cpu_writeback_tracker                                              |
// | Tracks write intents S2..S4, drives writeback, flags load-use hazards.     |
// | Optional feature macro: SLURM16_WB_STALL_STATS_EN (adds stall_count).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module slurm16_cpu_writeback_tracker
    import slurm16_cpu_writeback_tracker_pkg::*;
#(
    parameter int BITS          = 16,
    parameter int REGISTER_BITS = 4,
    parameter int NUM_REGS      = 16
) (
    input  logic                           CLK,
    input  logic                           RST,
    slurm16_cpu_writeback_tracker_if.slave bus
);

    logic [BITS-1:0]          slot_ins;
    wb_entry_t                decoded;
    wb_entry_t                slot_entry;
    wb_entry_t                s2;
    wb_entry_t                s3;
    wb_entry_t                s4;
    logic [NUM_REGS-1:0]      mask;
    logic [REGISTER_BITS-1:0] sel_a;
    logic [REGISTER_BITS-1:0] sel_b;
    logic                     hazard;

    assign slot_ins = bus.instruction;
    assign sel_a    = bus.hazard_regA_sel;
    assign sel_b    = bus.hazard_regB_sel;

    slurm16_cpu_wb_dest_decode u_dest_decode (
        .instruction (slot_ins),
        .entry       (decoded)
    );

    assign slot_entry = bus.ins_valid ? decoded : WB_BUBBLE;

    // Flush outranks stall; the S3 entry on a flush is the branch itself and retires.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s2 <= WB_BUBBLE;
            s3 <= WB_BUBBLE;
            s4 <= WB_BUBBLE;
        end else if (bus.flush) begin
            s2 <= WB_BUBBLE;
            s3 <= WB_BUBBLE;
            s4 <= s3;
        end else if (bus.stall) begin
            s4 <= WB_BUBBLE;
        end else begin
            s2 <= slot_entry;
            s3 <= s2;
            s4 <= s3;
        end
    end

    assign bus.wr_en  = s4.valid;
    assign bus.wr_sel = s4.valid ? s4.dest : '0;

    always_comb begin
        mask = '0;
        if (s2.valid) mask[s2.dest] = 1'b1;
        if (s3.valid) mask[s3.dest] = 1'b1;
        if (s4.valid) mask[s4.dest] = 1'b1;
        mask[0] = 1'b0;
    end

    assign bus.pending_mask = mask;

    // Only memory results still in S2/S3 cannot be forwarded in time.
    function automatic logic load_blocks(input wb_entry_t e, input logic [REGISTER_BITS-1:0] sel);
        return e.valid && e.is_mem && (sel != '0) && (e.dest == sel);
    endfunction

    assign hazard = load_blocks(s2, sel_a) || load_blocks(s3, sel_a) ||
                    load_blocks(s2, sel_b) || load_blocks(s3, sel_b);

    assign bus.hazard_stall = hazard;

`ifdef SLURM16_WB_STALL_STATS_EN
    logic [15:0] stall_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stall_count <= '0;
        else if (hazard && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
    end

    assign bus.stall_count = stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_slurm16_cpu_writeback_tracker.sv
// +----------------------------------------------------------------------------+
// | tb_slurm16_cpu_writeback_tracker                                           |
// | Directed + random stimulus against a token-queue model of the pipeline.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_slurm16_cpu_writeback_tracker;

    localparam logic [15:0] NOP       = 16'h0000;
    localparam logic [15:0] ADD_R3_R4 = 16'h2034;
    localparam logic [15:0] ADD_R2    = 16'h2021;
    localparam logic [15:0] ADD_R6    = 16'h2061;
    localparam logic [15:0] ADD_R7    = 16'h2071;
    localparam logic [15:0] MOV_R0_R1 = 16'h2001;
    localparam logic [15:0] LD_R5     = 16'h9050;
    localparam logic [15:0] BL        = 16'h4100;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    slurm16_cpu_writeback_tracker_if bus_if ();

    slurm16_cpu_writeback_tracker dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int dest;
        bit mem;
        int stage;
    } tok_t;

    tok_t        q[$];
    int          checks    = 0;
    int          errors    = 0;
    int          exp_count = 0;
    logic [15:0] cur_ins   = '0;
    bit          cur_v     = 1'b0;
    bit          cur_st    = 1'b0;
    bit          cur_fl    = 1'b0;
    logic [3:0]  cur_a     = '0;
    logic [3:0]  cur_b     = '0;

    // Architectural write rules by major opcode; 0 means "no register written".
    function automatic void model_decode(input logic [15:0] i, output int d, output bit m);
        d = 0;
        m = 1'b0;
        if (i[15]) begin
            if (i[12]) begin d = int'(i[7:4]); m = 1'b1; end
        end else begin
            case (i[15:12])
                4'h0: if (i[11:8] == 4'h4) d = int'(i[3:0]);
                4'h2, 4'h3: d = int'(i[7:4]);
                4'h4: if (i[8]) d = 15;
                4'h5: if (i[8]) begin d = int'(i[7:4]); m = 1'b1; end
                default: d = 0;
            endcase
        end
        if (d == 0) m = 1'b0;
    endfunction

    function automatic bit exp_wr_en();
        foreach (q[k]) if (q[k].stage == 4) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_wr_sel();
        foreach (q[k]) if (q[k].stage == 4) return 4'(q[k].dest);
        return 4'd0;
    endfunction

    function automatic logic [15:0] exp_pending();
        logic [15:0] p;
        p = '0;
        foreach (q[k]) p = p | (16'd1 << q[k].dest);
        p[0] = 1'b0;
        return p;
    endfunction

    function automatic bit exp_hazard(input logic [3:0] a, input logic [3:0] b);
        foreach (q[k])
            if ((q[k].stage == 2 || q[k].stage == 3) && q[k].mem &&
                ((a != 0 && q[k].dest == int'(a)) || (b != 0 && q[k].dest == int'(b))))
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] ins, input bit v, input bit st, input bit fl,
                         input logic [3:0] a, input logic [3:0] b);
        @(negedge CLK);
        bus_if.instruction     = ins;
        bus_if.ins_valid       = v;
        bus_if.stall           = st;
        bus_if.flush           = fl;
        bus_if.hazard_regA_sel = a;
        bus_if.hazard_regB_sel = b;
        cur_ins = ins; cur_v = v; cur_st = st; cur_fl = fl; cur_a = a; cur_b = b;
        #1;
        chk("wr_en", 32'(bus_if.wr_en), 32'(exp_wr_en()));
        chk("wr_sel", 32'(bus_if.wr_sel), 32'(exp_wr_sel()));
        chk("pending_mask", 32'(bus_if.pending_mask), 32'(exp_pending()));
        chk("hazard_stall", 32'(bus_if.hazard_stall), 32'(exp_hazard(a, b)));
`ifdef SLURM16_WB_STALL_STATS_EN
        chk("stall_count", 32'(bus_if.stall_count), 32'(exp_count));
`endif
    endtask

    task automatic tick();
        bit   hz;
        int   d;
        bit   m;
        tok_t nq[$];
        hz = exp_hazard(cur_a, cur_b);
        @(posedge CLK);
        if (hz && exp_count < 65535) exp_count++;
        foreach (q[k]) begin
            tok_t t;
            t = q[k];
            if (t.stage == 4) continue;
            if (cur_fl) begin
                if (t.stage == 3) begin t.stage = 4; nq.push_back(t); end
            end else if (cur_st) begin
                nq.push_back(t);
            end else begin
                t.stage++;
                nq.push_back(t);
            end
        end
        model_decode(cur_ins, d, m);
        if (!cur_fl && !cur_st && cur_v && d > 0) nq.push_back('{dest: d, mem: m, stage: 2});
        q = nq;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("rst_wr_en", 32'(bus_if.wr_en), 32'd0);
        chk("rst_pending", 32'(bus_if.pending_mask), 32'd0);
        chk("rst_hazard", 32'(bus_if.hazard_stall), 32'd0);
        q.delete();
        exp_count = 0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic step(input logic [15:0] ins, input bit st, input bit fl,
                        input logic [3:0] a, input logic [3:0] b);
        drive(ins, 1'b1, st, fl, a, b);
        tick();
    endtask

    function automatic logic [15:0] rand_ins();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 7))
            0: return {4'h2, r[11:0]};
            1: return {4'h3, r[11:0]};
            2: return {8'h04, r[7:0]};
            3: return {1'b1, r[14:0]};
            4: return {4'h5, r[11:0]};
            5: return {4'h4, r[11:0]};
            6: return r;
            default: return NOP;
        endcase
    endfunction

    initial begin
        logic [15:0] r_ins;
        bit          r_v, r_st, r_fl;
        logic [3:0]  r_a, r_b;

        bus_if.instruction     = '0;
        bus_if.ins_valid       = 1'b0;
        bus_if.stall           = 1'b0;
        bus_if.flush           = 1'b0;
        bus_if.hazard_regA_sel = '0;
        bus_if.hazard_regB_sel = '0;
        #12;
        chk("init_wr_en", 32'(bus_if.wr_en), 32'd0);
        chk("init_wr_sel", 32'(bus_if.wr_sel), 32'd0);
        chk("init_pending", 32'(bus_if.pending_mask), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // add r3, r4 retires three edges later
        do_reset();
        step(ADD_R3_R4, 0, 0, 0, 0);
        drive(NOP, 1, 0, 0, 0, 0);
        chk("add_pend_s2", 32'(bus_if.pending_mask), 32'h0008);
        chk("add_no_wr_s2", 32'(bus_if.wr_en), 32'd0);
        tick();
        step(NOP, 0, 0, 0, 0);
        drive(NOP, 1, 0, 0, 0, 0);
        chk("add_wr_en", 32'(bus_if.wr_en), 32'd1);
        chk("add_wr_sel", 32'(bus_if.wr_sel), 32'd3);
        chk("add_pend_s4", 32'(bus_if.pending_mask), 32'h0008);
        tick();
        drive(NOP, 1, 0, 0, 0, 0);
        chk("add_wr_done", 32'(bus_if.wr_en), 32'd0);
        tick();

        // load-use on r5 via read select B
        do_reset();
        step(LD_R5, 0, 0, 0, 0);
        drive(NOP, 1, 0, 0, 0, 5);
        chk("lu_s2", 32'(bus_if.hazard_stall), 32'd1);
        tick();
        drive(NOP, 1, 0, 0, 0, 5);
        chk("lu_s3", 32'(bus_if.hazard_stall), 32'd1);
        tick();
        drive(NOP, 1, 0, 0, 0, 5);
        chk("lu_s4", 32'(bus_if.hazard_stall), 32'd0);
`ifdef SLURM16_WB_STALL_STATS_EN
        chk("lu_count", 32'(bus_if.stall_count), 32'd2);
`endif
        tick();

        // r0 read selects never hazard; writes to r0 never happen
        do_reset();
        step(LD_R5, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(NOP, 0, 0, 0, 0);
        step(MOV_R0_R1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(NOP, 1, 0, 0, 0, 0);
            chk("mov_r0_no_wr", 32'(bus_if.wr_en), 32'd0);
            tick();
        end

        // flush (with stall also high) keeps the link branch, kills r2/r6
        do_reset();
        step(BL, 0, 0, 0, 0);
        step(ADD_R2, 0, 0, 0, 0);
        step(ADD_R6, 1, 1, 0, 0);
        drive(NOP, 1, 0, 0, 0, 0);
        chk("fl_link_wr", 32'(bus_if.wr_en), 32'd1);
        chk("fl_link_sel", 32'(bus_if.wr_sel), 32'd15);
        chk("fl_pend", 32'(bus_if.pending_mask), 32'h8000);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(NOP, 1, 0, 0, 0, 0);
            chk("fl_no_wr", 32'(bus_if.wr_en), 32'd0);
            tick();
        end

        // r7 held in S3 across four stall cycles retires exactly once
        do_reset();
        step(ADD_R7, 0, 0, 0, 0);
        step(NOP, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(NOP, 1, 1, 0, 0, 0);
            chk("st_bubble", 32'(bus_if.wr_en), 32'd0);
            tick();
        end
        drive(NOP, 1, 0, 0, 0, 0);
        chk("st_pend", 32'(bus_if.pending_mask), 32'h0080);
        tick();
        drive(NOP, 1, 0, 0, 0, 0);
        chk("st_wr_en", 32'(bus_if.wr_en), 32'd1);
        chk("st_wr_sel", 32'(bus_if.wr_sel), 32'd7);
        tick();
        drive(NOP, 1, 0, 0, 0, 0);
        chk("st_once", 32'(bus_if.wr_en), 32'd0);
        tick();

        // asynchronous reset mid-cycle with three entries in flight
        do_reset();
        step(ADD_R2, 0, 0, 0, 0);
        step(ADD_R3_R4, 0, 0, 0, 0);
        step(ADD_R6, 0, 0, 0, 0);
        drive(NOP, 1, 0, 0, 0, 0);
        chk("ar_pre_wr", 32'(bus_if.wr_en), 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("ar_wr_en", 32'(bus_if.wr_en), 32'd0);
        chk("ar_wr_sel", 32'(bus_if.wr_sel), 32'd0);
        chk("ar_pending", 32'(bus_if.pending_mask), 32'd0);
        q.delete();
        exp_count = 0;
        @(negedge CLK);
        RST = 1'b0;
        step(ADD_R7, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(NOP, 1, 0, 0, 0, 0);
            chk("ar_no_early_wr", 32'(bus_if.wr_en), 32'd0);
            tick();
        end
        drive(NOP, 1, 0, 0, 0, 0);
        chk("ar_new_wr_sel", 32'(bus_if.wr_sel), 32'd7);
        tick();

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r_ins = rand_ins();
            r_v   = ($urandom_range(0, 7) != 0);
            r_st  = ($urandom_range(0, 4) == 0);
            r_fl  = ($urandom_range(0, 9) == 0);
            r_a   = 4'($urandom_range(0, 15));
            r_b   = 4'($urandom_range(0, 15));
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                r_a = 4'(q[$urandom_range(0, q.size() - 1)].dest);
            if (q.size() > 0 && $urandom_range(0, 2) == 0)
                r_b = 4'(q[$urandom_range(0, q.size() - 1)].dest);
            drive(r_ins, r_v, r_st, r_fl, r_a, r_b);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slurm16_cpu_writeback_tracker.md
Name: slurm16_cpu_writeback_tracker

Overview:
- Write-side counterpart to the register read-select decoder.
- Decodes each instruction entering pipeline stage 1 into a destination-register write intent, then carries that intent through stages 2-4.
- Drives the register-file write select/enable at writeback (stage 4).
- Flags load-use hazards against the stage-0 hazard decoder's read selects, so the pipeline controller can stall.

Parameters:
- BITS, 16, instruction width
- REGISTER_BITS, 4, register select width (16 registers, r0 hardwired zero)
- NUM_REGS, 16, width of pending-destination mask

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous reset, active-high
- instruction  in  BITS  instruction in pipeline slot 1
- ins_valid  in  1  slot 1 holds a real instruction (0 = bubble)
- stall  in  1  pipeline hold from pipeline controller
- flush  in  1  branch taken; kill stage 2 and stage 3 entries
- hazard_regA_sel  in  REGISTER_BITS  stage-0 read select A
- hazard_regB_sel  in  REGISTER_BITS  stage-0 read select B
- wr_sel  out  REGISTER_BITS  register-file write address (registered)
- wr_en  out  1  register-file write enable (registered)
- hazard_stall  out  1  load-use hazard, combinational
- pending_mask  out  NUM_REGS  one-hot OR of valid stage 2-4 destinations, combinational, bit 0 always 0

Behaviour:
- Entry = {valid, dest[3:0], is_mem}. Stages S2, S3, S4 are registered entries; S4 drives wr_sel/wr_en.
- Destination decode of the slot-1 instruction, using the shared casex classes:
  - ALUOP_SINGLE_REG: dest = reg_src_from_ins.
  - ALUOP_REG_REG, ALUOP_REG_IMM: dest = reg_dest_from_ins.
  - LOAD_STORE with is_load_from_ins = 1: dest = reg_dest_from_ins, is_mem = 1.
  - PEEK_POKE with is_peek_from_ins = 1: dest = reg_dest_from_ins, is_mem = 1.
  - BRANCH with is_link_from_ins = 1: dest = LINK_REGISTER.
  - NOP, RET/IRET, store, poke, non-link branch, default: no write, valid = 0.
  - Any decoded dest of 0 forces valid = 0.
- Normal clock (stall = 0, flush = 0): S2 <= decode(instruction) & ins_valid; S3 <= S2; S4 <= S3.
- stall = 1, flush = 0: S2 and S3 hold; S4 <= bubble, so an entry retires exactly once.
- flush = 1 (priority over stall): S2 and S3 <= bubble; S4 <= S3 as on a normal clock. The instruction being flushed in S3 is the branch itself and still retires.
- wr_en = S4.valid; wr_sel = S4.dest, or 0 when not valid.
- hazard_stall = 1 when, for either hazard sel X != 0, some S2 or S3 entry has valid & is_mem & dest == X.
  - ALU results are forwarded from S3/S4 and never cause a hazard.
  - S4 loads are forwarded and never cause a hazard.
- Both hazard sels may match different entries; the result is still a single stall.
- Same dest in several stages: no special handling; the youngest entry wins at the forwarding mux, which is outside this block.
- Reset (asynchronous, any cycle, including mid-stall):
  - S2/S3/S4 <= bubble.
  - wr_en = 0, wr_sel = 0, pending_mask = 0, hazard_stall = 0.
  - First write after RST deasserts: no earlier than 3 clocks after the first valid instruction.
- Latency: slot-1 instruction to wr_en = 3 clock edges, plus one edge per stall cycle it sees in S2/S3.

Optional Feature:
- Macro: SLURM16_WB_STALL_STATS_EN.
- Defined:
  - Adds output stall_count [15:0].
  - Increments each clock where hazard_stall = 1; saturates at 16'hFFFF.
  - Cleared by RST.
- Undefined:
  - Port and counter absent.
  - All other behaviour identical.

Decomposition:
- Shared package (cpu_defs / cpu_decode_functions):
  - Add is_load_from_ins, is_peek_from_ins, is_link_from_ins.
  - Add wb entry field widths and the bubble constant.
  - Reuse the existing INSTRUCTION_CASEX_* classes, LINK_REGISTER, reg_dest_from_ins and reg_src_from_ins.
- One sub-module, slurm16_cpu_wb_dest_decode: combinational instruction -> {valid, dest, is_mem}. It is reused later by the retire/trace logic.

Test Plan:
- "add r3, r4" at slot 1 with ins_valid = 1, then NOPs -> exactly 3 edges later wr_en = 1 and wr_sel = 3 for one cycle; pending_mask = 16'h0008 during S2-S4.
- Load into r5, next cycle hazard_regB_sel = 5 -> hazard_stall = 1 while the load is in S2 and S3, 0 once it is in S4. With the macro defined, stall_count = 2.
- Load into r5 with hazard_regA_sel = 0 and hazard_regB_sel = 0 -> hazard_stall stays 0. Same for "mov r0, r1": wr_en never asserts.
- Link branch in S3 with flush = 1, two ALU writes (r2, r6) in S2/S1 -> LINK_REGISTER is written next cycle; r2 and r6 are never written.
- ALU write r7 in S3 with stall = 1 for 4 cycles -> wr_en pulses for r7 only after stall releases, exactly once; S4 shows bubbles during the stall.
- RST asserted asynchronously mid-cycle with 3 valid entries in flight -> wr_en drops immediately without waiting for a clock edge; pending_mask = 0; no writes after release until new instructions have advanced 3 stages.
